// File: rtl/audio_pkg.sv
// Shared audio framing types and constants; also consumed by the autocorrelation stage.
package audio_pkg;
   localparam int FRAME_LEN = 480;
   localparam int SAMPLE_W  = 32;
   localparam int ACC_W     = SAMPLE_W + $clog2(FRAME_LEN);
   localparam int CNT_W     = $clog2(FRAME_LEN + 1);
   localparam logic [63:0] ENERGY_THR = 64'd1 << 35;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef sample_t frame_t [FRAME_LEN];

   typedef enum logic {ST_FILL, ST_PUBLISH} state_e;

   // Unsigned magnitude; the most negative sample maps to 2^(SAMPLE_W-1) without overflow.
   function automatic logic [SAMPLE_W-1:0] abs_u(input sample_t x);
      logic [SAMPLE_W-1:0] ux;
      ux = x;
      return ux[SAMPLE_W-1] ? (~ux + SAMPLE_W'(1)) : ux;
   endfunction
endpackage

// File: rtl/abs_energy_acc.sv
// Running sum of |x| over a frame. sum_o includes the current sample so the
// frame total is available on the same cycle as the final strobe.
module abs_energy_acc
   import audio_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             en_i,
   input  sample_t          sample_i,
   output logic [ACC_W-1:0] sum_o
);
   logic [ACC_W-1:0] acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (en_i) acc_d = acc_q + ACC_W'(abs_u(sample_i));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) acc_q <= '0;
      else                  acc_q <= acc_d;
   end

   assign sum_o = acc_d;
endmodule

// File: rtl/frame_collector_vad.sv
// Packs streamed samples into frames, classifies each as voiced/unvoiced by
// mean-absolute energy, and publishes stable frames to the autocorrelation engine.
module frame_collector_vad
   import audio_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset_h,
   input  sample_t          sample_in,
   input  logic             sample_valid,
   input  logic             consumer_busy,
   output frame_t           soundIn,
   output logic             frame_ready,
   output logic             isVoice,
   output logic             overrun,
   output logic [CNT_W-1:0] fill_count
);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

   sample_t          wbuf_q [FRAME_LEN];
   frame_t           sound_q;
   logic [CNT_W-1:0] idx_q, idx_d;
   state_e           state_q, state_d;
   logic             voice_q, ovr_q;
   logic             complete, publish;
   logic [ACC_W-1:0] sum;

   assign complete = sample_valid && (idx_q == LAST_IDX);
   assign publish  = complete && !consumer_busy;

   abs_energy_acc u_acc (
      .clk_i   (Clk),
      .rst_i   (Reset_h),
      .clear_i (complete),
      .en_i    (sample_valid),
      .sample_i(sample_in),
      .sum_o   (sum)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      frame_ready = 1'b0;
      case (state_q)
         ST_FILL:    if (publish) state_d = ST_PUBLISH;
         ST_PUBLISH: begin
            frame_ready = 1'b1;
            state_d     = ST_FILL;
         end
         default:    state_d = ST_FILL;
      endcase
      if (complete)          idx_d = '0;
      else if (sample_valid) idx_d = idx_q + CNT_W'(1);
   end

   always_ff @(posedge Clk) begin
      if (!Reset_h && sample_valid) wbuf_q[idx_q] <= sample_in;
   end

   always_ff @(posedge Clk) begin
      if (Reset_h) begin
         state_q <= ST_FILL;
         idx_q   <= '0;
         voice_q <= 1'b0;
         ovr_q   <= 1'b0;
         sound_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (complete && consumer_busy) ovr_q <= 1'b1;
         // The final sample bypasses wbuf so the frame is published one cycle after its strobe.
         if (publish) begin
            voice_q <= (64'(sum) > ENERGY_THR);
            for (int k = 0; k < FRAME_LEN - 1; k++) sound_q[k] <= wbuf_q[k];
            sound_q[FRAME_LEN-1] <= sample_in;
         end
      end
   end

   assign soundIn    = sound_q;
   assign isVoice    = voice_q;
   assign overrun    = ovr_q;
   assign fill_count = idx_q;
endmodule

// File: tb/tb_frame_collector_vad.sv
// Table-driven frames plus hand sequences; published frames checked against a scoreboard queue.
module tb_frame_collector_vad;
   import audio_pkg::*;

   localparam int FW = FRAME_LEN * SAMPLE_W;

   logic             Clk = 1'b0;
   logic             Reset_h = 1'b1;
   logic             sample_valid = 1'b0;
   logic             consumer_busy = 1'b0;
   sample_t          sample_in = '0;
   frame_t           soundIn;
   logic             frame_ready, isVoice, overrun;
   logic [CNT_W-1:0] fill_count;

   frame_collector_vad dut (
      .Clk          (Clk),
      .Reset_h      (Reset_h),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .consumer_busy(consumer_busy),
      .soundIn      (soundIn),
      .frame_ready  (frame_ready),
      .isVoice      (isVoice),
      .overrun      (overrun),
      .fill_count   (fill_count)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int   kind;
      logic busy;
      logic vexp;
      logic ovr;
   } vec_t;

   vec_t        vecs [6];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [FW-1:0] exp_data_q [$];
   logic          exp_voice_q [$];
   logic [FW-1:0] cur, pub_data;
   logic          pub_voice;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [FW-1:0] pack_snd();
      logic [FW-1:0] p;
      for (int k = 0; k < FRAME_LEN; k++) p[k*SAMPLE_W +: SAMPLE_W] = soundIn[k];
      return p;
   endfunction

   task automatic chk_frame(input string name, input logic [FW-1:0] exp);
      logic [FW-1:0] act;
      int bad;
      act = pack_snd();
      bad = -1;
      n_tests++;
      for (int k = 0; k < FRAME_LEN; k++)
         if (bad < 0 && act[k*SAMPLE_W +: SAMPLE_W] !== exp[k*SAMPLE_W +: SAMPLE_W]) bad = k;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s: word %0d got %0d, expected %0d", name, bad,
                  $signed(act[bad*SAMPLE_W +: SAMPLE_W]), $signed(exp[bad*SAMPLE_W +: SAMPLE_W]));
      end
   endtask

   function automatic sample_t samp(input int kind, input int i);
      int k;
      k = i % FRAME_LEN;
      case (kind)
         0: return sample_t'(1000);
         1: return (k % 2 == 0) ? sample_t'(32'h4000_0000) : sample_t'(32'hC000_0000);
         2: return sample_t'(32'h8000_0000);
         3: return sample_t'(i * 7 - 1500);
         4: return (k == FRAME_LEN - 1) ? sample_t'(71582916) : sample_t'(71582788);
         5: return (k == FRAME_LEN - 1) ? sample_t'(71582917) : sample_t'(71582788);
         default: return '0;
      endcase
   endfunction

   // Streams n samples back-to-back starting from an empty write buffer.
   task automatic stream(input int kind, input int n, input logic busy, input logic vexp);
      int m;
      for (int i = 0; i <= n; i++) begin
         @(posedge Clk); #1;
         m = i % FRAME_LEN;
         if (i > 0 && (m == 0 || m == 1 || m == FRAME_LEN - 1 || i == n)) begin
            chk("fill_count", 64'(fill_count), 64'(m));
            chk("frame_ready", 64'(frame_ready), (m == 0) ? 64'(!busy) : 64'd0);
         end
         if (i < n) begin
            sample_valid = 1'b1;
            sample_in    = samp(kind, i);
            cur[m*SAMPLE_W +: SAMPLE_W] = sample_in;
            consumer_busy = (m == FRAME_LEN - 1) ? busy : 1'b0;
            if (m == FRAME_LEN - 1 && !busy) begin
               exp_data_q.push_back(cur);
               exp_voice_q.push_back(vexp);
               pub_data  = cur;
               pub_voice = vexp;
            end
         end else begin
            sample_valid  = 1'b0;
            consumer_busy = 1'b0;
         end
      end
   endtask

   task automatic chk_reset_state();
      chk("rst_fill_count", 64'(fill_count), 64'd0);
      chk("rst_frame_ready", 64'(frame_ready), 64'd0);
      chk("rst_isVoice", 64'(isVoice), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      chk_frame("rst_soundIn", '0);
   endtask

   always @(negedge Clk) begin : mon
      logic [FW-1:0] e;
      logic          v;
      if (!Reset_h && frame_ready) begin
         if (exp_data_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame_ready: got 1, expected 0");
         end else begin
            e = exp_data_q.pop_front();
            v = exp_voice_q.pop_front();
            chk_frame("pub_soundIn", e);
            chk("pub_isVoice", 64'(isVoice), 64'(v));
         end
      end
   end

   initial begin
      vecs[0] = '{kind: 0, busy: 1'b0, vexp: 1'b0, ovr: 1'b0};
      vecs[1] = '{kind: 1, busy: 1'b1, vexp: 1'b0, ovr: 1'b1};
      vecs[2] = '{kind: 1, busy: 1'b0, vexp: 1'b1, ovr: 1'b1};
      vecs[3] = '{kind: 2, busy: 1'b0, vexp: 1'b1, ovr: 1'b1};
      vecs[4] = '{kind: 4, busy: 1'b0, vexp: 1'b0, ovr: 1'b1};
      vecs[5] = '{kind: 5, busy: 1'b0, vexp: 1'b1, ovr: 1'b1};
      cur       = '0;
      pub_data  = '0;
      pub_voice = 1'b0;

      repeat (3) @(posedge Clk);
      #1;
      chk_reset_state();
      Reset_h = 1'b0;

      for (int v = 0; v < 6; v++) begin
         stream(vecs[v].kind, FRAME_LEN, vecs[v].busy, vecs[v].vexp);
         chk("overrun", 64'(overrun), 64'(vecs[v].ovr));
         chk_frame("soundIn_held", pub_data);
         chk("isVoice_held", 64'(isVoice), 64'(pub_voice));
      end

      // Two frames with no gap: sample 481 becomes word 0 of the second frame.
      stream(3, 2 * FRAME_LEN, 1'b0, 1'b0);

      // Reset mid-fill discards the partial frame and clears the sticky overrun.
      stream(3, 200, 1'b0, 1'b0);
      Reset_h = 1'b1;
      @(posedge Clk); #1;
      Reset_h = 1'b0;
      chk_reset_state();
      pub_data  = '0;
      pub_voice = 1'b0;
      stream(4, FRAME_LEN, 1'b0, 1'b0);
      chk("overrun_after_reset", 64'(overrun), 64'd0);

      repeat (3) @(posedge Clk);
      #1;
      chk("scoreboard_empty", 64'(exp_data_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
